rtc_set_ctrl: RTL



---
 rtl/rtc_pkg.sv | 117 +++++++++++
 rtl/rtc_bcd_step.sv | 53 +++++
 rtl/rtc_set_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// ---------------------------------------------------------------------------
// rtc_pkg
//   Shared definitions for the RTC time-setting controller:
//   - controller state enum and display page enum
//   - edit field indices (order in which key_sel_p walks the fields)
//   - per-field BCD range limits
//   - display layout constants and per-field blink masks
//   - small helper functions mapping a field index to its range, page and mask
// ---------------------------------------------------------------------------
package rtc_pkg;

  typedef enum logic [2:0] {
    S_DISP_TIME = 3'd0,
    S_DISP_DATE = 3'd1,
    S_DISP_YEAR = 3'd2,
    S_EDIT      = 3'd3,
    S_COMMIT    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PAGE_TIME = 2'd0,
    PAGE_DATE = 2'd1,
    PAGE_YEAR = 2'd2
  } page_t;

  // Edit field indices; key_sel_p walks them in this order and wraps.
  localparam int         NUM_FIELDS = 7;
  localparam logic [2:0] F_HOUR   = 3'd0;
  localparam logic [2:0] F_MINUTE = 3'd1;
  localparam logic [2:0] F_SECOND = 3'd2;
  localparam logic [2:0] F_YEAR   = 3'd3;
  localparam logic [2:0] F_MONTH  = 3'd4;
  localparam logic [2:0] F_DATE   = 3'd5;
  localparam logic [2:0] F_WEEK   = 3'd6;
  localparam logic [2:0] F_LAST   = F_WEEK;

  // BCD range limits per field.
  localparam logic [7:0] HOUR_MIN  = 8'h00;
  localparam logic [7:0] HOUR_MAX  = 8'h23;
  localparam logic [7:0] MS_MIN    = 8'h00;
  localparam logic [7:0] MS_MAX    = 8'h59;
  localparam logic [7:0] YEAR_MIN  = 8'h00;
  localparam logic [7:0] YEAR_MAX  = 8'h99;
  localparam logic [7:0] MONTH_MIN = 8'h01;
  localparam logic [7:0] MONTH_MAX = 8'h12;
  localparam logic [7:0] DATE_MIN  = 8'h01;
  localparam logic [7:0] DATE_MAX  = 8'h31;
  localparam logic [7:0] WEEK_MIN  = 8'h01;
  localparam logic [7:0] WEEK_MAX  = 8'h07;

  // Display layout: the YEAR page shows "20yy-w" as {20, yy, 0, w}.
  localparam logic [7:0] CENTURY_BCD = 8'h20;
  localparam logic [3:0] YEAR_PAGE_GAP = 4'h0;

  // Blink masks, bit 5 = leftmost digit.
  localparam logic [5:0] BLANK_NONE  = 6'b000000;
  localparam logic [5:0] BLANK_LEFT  = 6'b110000;
  localparam logic [5:0] BLANK_MID   = 6'b001100;
  localparam logic [5:0] BLANK_RIGHT = 6'b000011;
  localparam logic [5:0] BLANK_LAST  = 6'b000001;

  // Lower bound of a field; also the value the edit buffer resets to.
  function automatic logic [7:0] field_min(input logic [2:0] f);
    logic [7:0] v;
    case (f)
      F_HOUR:   v = HOUR_MIN;
      F_MINUTE: v = MS_MIN;
      F_SECOND: v = MS_MIN;
      F_YEAR:   v = YEAR_MIN;
      F_MONTH:  v = MONTH_MIN;
      F_DATE:   v = DATE_MIN;
      F_WEEK:   v = WEEK_MIN;
      default:  v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] field_max(input logic [2:0] f);
    logic [7:0] v;
    case (f)
      F_HOUR:   v = HOUR_MAX;
      F_MINUTE: v = MS_MAX;
      F_SECOND: v = MS_MAX;
      F_YEAR:   v = YEAR_MAX;
      F_MONTH:  v = MONTH_MAX;
      F_DATE:   v = DATE_MAX;
      F_WEEK:   v = WEEK_MAX;
      default:  v = 8'h00;
    endcase
    return v;
  endfunction

  // Page on which a field is edited.
  function automatic page_t field_page(input logic [2:0] f);
    page_t p;
    case (f)
      F_HOUR, F_MINUTE, F_SECOND: p = PAGE_TIME;
      F_YEAR, F_MONTH, F_DATE:    p = PAGE_DATE;
      default:                    p = PAGE_YEAR;
    endcase
    return p;
  endfunction

  // Digits occupied by a field on its page.
  function automatic logic [5:0] field_blank_mask(input logic [2:0] f);
    logic [5:0] m;
    case (f)
      F_HOUR, F_YEAR:    m = BLANK_LEFT;
      F_MINUTE, F_MONTH: m = BLANK_MID;
      F_SECOND, F_DATE:  m = BLANK_RIGHT;
      F_WEEK:            m = BLANK_LAST;
      default:           m = BLANK_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rtc_bcd_step.sv
// ---------------------------------------------------------------------------
// rtc_bcd_step
//   Combinational one-step BCD increment/decrement with range wrap.
//   Ports:
//     value_in  [7:0]  current two-digit BCD value
//     step_up          1 = increment, 0 = decrement
//     min_val   [7:0]  lowest legal BCD value of the field
//     max_val   [7:0]  highest legal BCD value of the field
//     value_out [7:0]  stepped value
//   A value that is not valid BCD or lies outside [min_val, max_val]
//   steps to min_val regardless of direction, so a corrupt snapshot is
//   always pulled back into range by the first key press.
// ---------------------------------------------------------------------------
module rtc_bcd_step (
  input  logic [7:0] value_in,
  input  logic       step_up,
  input  logic [7:0] min_val,
  input  logic [7:0] max_val,
  output logic [7:0] value_out
);

  logic in_range;

  always_comb begin
    // Valid BCD bytes order the same as their binary encodings, so a plain
    // magnitude compare against BCD limits is correct once the digits are
    // known to be 0-9.
    in_range = (value_in[3:0] <= 4'd9) && (value_in[7:4] <= 4'd9) &&
               (value_in >= min_val) && (value_in <= max_val);

    value_out = min_val;
    if (in_range) begin
      if (step_up) begin
        if (value_in == max_val) begin
          value_out = min_val;
        end else if (value_in[3:0] == 4'd9) begin
          value_out = {value_in[7:4] + 4'd1, 4'd0};
        end else begin
          value_out = value_in + 8'd1;
        end
      end else begin
        if (value_in == min_val) begin
          value_out = max_val;
        end else if (value_in[3:0] == 4'd0) begin
          value_out = {value_in[7:4] - 4'd1, 4'd9};
        end else begin
          value_out = value_in - 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/rtc_set_ctrl.sv
// ---------------------------------------------------------------------------
// rtc_set_ctrl
//   Time-setting controller between the key debouncers, the seven-segment
//   driver and the DS1302 read/write engine.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     key_mode_p/sel_p/up_p/down_p  one-cycle key pulses (mode > sel > up > down)
//     read_*  [7:0]             live BCD registers from the DS1302 engine
//     write_* [7:0]             edit buffer presented to the DS1302 engine
//     wr_req / wr_ack           write handshake (ack is a one-cycle pulse)
//     disp_bcd [23:0]           six BCD digits, leftmost digit in [23:20]
//     disp_blank [5:0]          per-digit blank, bit 5 = leftmost digit
//     edit_active               high while editing or committing
//   Parameter:
//     BLINK_CNT                 clk cycles per blink half-period, minus one
// ---------------------------------------------------------------------------
module rtc_set_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned BLINK_CNT = 12_499_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode_p,
  input  logic        key_sel_p,
  input  logic        key_up_p,
  input  logic        key_down_p,
  input  logic [7:0]  read_second,
  input  logic [7:0]  read_minute,
  input  logic [7:0]  read_hour,
  input  logic [7:0]  read_date,
  input  logic [7:0]  read_month,
  input  logic [7:0]  read_week,
  input  logic [7:0]  read_year,
  output logic [7:0]  write_second,
  output logic [7:0]  write_minute,
  output logic [7:0]  write_hour,
  output logic [7:0]  write_date,
  output logic [7:0]  write_month,
  output logic [7:0]  write_week,
  output logic [7:0]  write_year,
  output logic        wr_req,
  input  logic        wr_ack,
  output logic [23:0] disp_bcd,
  output logic [5:0]  disp_blank,
  output logic        edit_active
);

  localparam int CNT_W = (BLINK_CNT < 1) ? 1 : $clog2(BLINK_CNT + 1);

  // -------------------------------------------------------------------------
  // Key priority decode: only the highest-priority pulse acts.
  // -------------------------------------------------------------------------
  logic act_mode, act_sel, act_up, act_down, any_key;

  assign act_mode = key_mode_p;
  assign act_sel  = !key_mode_p && key_sel_p;
  assign act_up   = !key_mode_p && !key_sel_p && key_up_p;
  assign act_down = !key_mode_p && !key_sel_p && !key_up_p && key_down_p;
  assign any_key  = key_mode_p || key_sel_p || key_up_p || key_down_p;

  state_t     state_reg, state_next;
  logic [2:0] field_reg, field_next;
  logic       in_disp, snapshot_en, step_en;

  assign in_disp     = (state_reg == S_DISP_TIME) || (state_reg == S_DISP_DATE) ||
                       (state_reg == S_DISP_YEAR);
  assign snapshot_en = in_disp && act_mode;
  assign step_en     = (state_reg == S_EDIT) && (act_up || act_down);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_DISP_TIME;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_DISP_TIME: begin
        if (act_mode)     state_next = S_EDIT;
        else if (act_sel) state_next = S_DISP_DATE;
      end
      S_DISP_DATE: begin
        if (act_mode)     state_next = S_EDIT;
        else if (act_sel) state_next = S_DISP_YEAR;
      end
      S_DISP_YEAR: begin
        if (act_mode)     state_next = S_EDIT;
        else if (act_sel) state_next = S_DISP_TIME;
      end
      S_EDIT: begin
        if (act_mode) state_next = S_COMMIT;
      end
      S_COMMIT: begin
        // Keys are ignored here; only the engine's acknowledge leaves.
        if (wr_ack) state_next = S_DISP_TIME;
      end
      default: state_next = S_DISP_TIME;
    endcase
  end

  // FSM: outputs
  always_comb begin
    wr_req      = 1'b0;
    edit_active = 1'b0;
    case (state_reg)
      S_EDIT: begin
        edit_active = 1'b1;
      end
      S_COMMIT: begin
        edit_active = 1'b1;
        wr_req      = 1'b1;
      end
      default: begin
        wr_req      = 1'b0;
        edit_active = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Active field selector
  // -------------------------------------------------------------------------
  always_comb begin
    field_next = field_reg;
    if (snapshot_en) begin
      field_next = F_HOUR;
    end else if ((state_reg == S_EDIT) && act_sel) begin
      field_next = (field_reg == F_LAST) ? F_HOUR : field_reg + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      field_reg <= F_HOUR;
    end else begin
      field_reg <= field_next;
    end
  end

  // -------------------------------------------------------------------------
  // Edit buffer: one byte per field, indexed by field number.
  // -------------------------------------------------------------------------
  logic [7:0] read_val [NUM_FIELDS];
  logic [7:0] edit_val [NUM_FIELDS];
  logic [7:0] step_in, step_out;

  assign read_val[F_HOUR]   = read_hour;
  assign read_val[F_MINUTE] = read_minute;
  assign read_val[F_SECOND] = read_second;
  assign read_val[F_YEAR]   = read_year;
  assign read_val[F_MONTH]  = read_month;
  assign read_val[F_DATE]   = read_date;
  assign read_val[F_WEEK]   = read_week;

  // A single stepper serves whichever field is active.
  assign step_in = edit_val[field_reg];

  rtc_bcd_step u_bcd_step (
    .value_in  (step_in),
    .step_up   (act_up),
    .min_val   (field_min(field_reg)),
    .max_val   (field_max(field_reg)),
    .value_out (step_out)
  );

  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
    logic [7:0] value_reg;

    // Reset value equals the field minimum (00, or 01 for month/date/week).
    always_ff @(posedge clk) begin
      if (rst) begin
        value_reg <= field_min(3'(gi));
      end else if (snapshot_en) begin
        value_reg <= read_val[gi];
      end else if (step_en && (field_reg == 3'(gi))) begin
        value_reg <= step_out;
      end
    end

    assign edit_val[gi] = value_reg;
  end

  // The CH bit of seconds and the 12/24 bit of hours are never written as 1,
  // even if the snapshot carried them; the stepper treats such a byte as out
  // of range and replaces it on the first step.
  assign write_hour   = {1'b0, edit_val[F_HOUR][6:0]};
  assign write_minute = edit_val[F_MINUTE];
  assign write_second = {1'b0, edit_val[F_SECOND][6:0]};
  assign write_year   = edit_val[F_YEAR];
  assign write_month  = edit_val[F_MONTH];
  assign write_date   = edit_val[F_DATE];
  assign write_week   = edit_val[F_WEEK];

  // -------------------------------------------------------------------------
  // Blink timebase: free-running, restarted in the on phase by any key in
  // S_EDIT so the field being changed is visible right after the press.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] blink_cnt_reg;
  logic             blink_on_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
    end else if ((state_reg == S_EDIT) && any_key) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
    end else if (blink_cnt_reg == CNT_W'(BLINK_CNT)) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= !blink_on_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Registered display mux
  // -------------------------------------------------------------------------
  page_t      disp_page;
  logic       use_edit;
  logic [7:0] src_val [NUM_FIELDS];
  logic [23:0] disp_bcd_next, disp_bcd_reg;
  logic [5:0]  disp_blank_next, disp_blank_reg;

  always_comb begin
    disp_page = PAGE_TIME;
    use_edit  = 1'b0;
    case (state_reg)
      S_DISP_TIME: disp_page = PAGE_TIME;
      S_DISP_DATE: disp_page = PAGE_DATE;
      S_DISP_YEAR: disp_page = PAGE_YEAR;
      default: begin
        // While editing/committing the page follows the active field.
        disp_page = field_page(field_reg);
        use_edit  = 1'b1;
      end
    endcase
  end

  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_src
    assign src_val[gi] = use_edit ? edit_val[gi] : read_val[gi];
  end

  always_comb begin
    case (disp_page)
      PAGE_TIME: disp_bcd_next = {src_val[F_HOUR], src_val[F_MINUTE], src_val[F_SECOND]};
      PAGE_DATE: disp_bcd_next = {src_val[F_YEAR], src_val[F_MONTH], src_val[F_DATE]};
      default:   disp_bcd_next = {CENTURY_BCD, src_val[F_YEAR], YEAR_PAGE_GAP,
                                  src_val[F_WEEK][3:0]};
    endcase

    disp_blank_next = BLANK_NONE;
    if ((state_reg == S_EDIT) && !blink_on_reg) begin
      disp_blank_next = field_blank_mask(field_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_bcd_reg   <= '0;
      disp_blank_reg <= BLANK_NONE;
    end else begin
      disp_bcd_reg   <= disp_bcd_next;
      disp_blank_reg <= disp_blank_next;
    end
  end

  assign disp_bcd   = disp_bcd_reg;
  assign disp_blank = disp_blank_reg;

endmodule
